// File: rtl/j1_soc_pkg.sv
// rtl/j1_soc_pkg.sv - shared types and address predicates for the J1 SoC IO path
package j1_soc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    // addr[15:14] equal to this pattern selects RAM rather than IO space
    localparam logic [1:0] IO_SPACE_MASK = 2'b00;

    function automatic logic is_ram_addr(input logic [15:0] addr);
        return addr[15:14] == IO_SPACE_MASK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with a registered at-or-above-threshold flag
module sat_counter #(
    parameter int W      = 8,
    parameter int THRESH = 200
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic reached_o
);

    localparam logic [W-1:0] THRESH_W = W'(THRESH);

    logic [W-1:0] cnt_q, cnt_d;
    logic         reached_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // flag follows the next count so it drops in the same edge the count clears
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            reached_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            reached_q <= (cnt_d >= THRESH_W);
        end
    end

    assign reached_o = reached_q;

endmodule

// File: rtl/j1_io_arbiter.sv
// rtl/j1_io_arbiter.sv - shares the J1 IO bus between the CPU and a secondary req/ack master
module j1_io_arbiter
    import j1_soc_pkg::*;
#(
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        j1_rd,
    input  logic        j1_wr,
    input  logic [15:0] j1_addr,
    input  logic [15:0] j1_dout,
    output logic [15:0] j1_din,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [15:0] m_addr,
    input  logic [15:0] m_wdata,
    output logic        m_ack,
    output logic        m_err,
    output logic [15:0] m_rdata,
    output logic        p_rd,
    output logic        p_wr,
    output logic [15:0] p_addr,
    output logic [15:0] p_dout,
    input  logic [15:0] p_din,
    output logic        starve,
    output logic [15:0] grant_cnt
);

    arb_state_e  state_q, state_d;
    logic        cmd_we_q, cmd_we_d;
    logic [15:0] cmd_addr_q, cmd_addr_d;
    logic [15:0] cmd_wdata_q, cmd_wdata_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic        wait_inc, wait_clr;
    logic        cpu_act;

    assign cpu_act = j1_rd | j1_wr;
    assign j1_din  = p_din;

    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        grant_cnt_d = grant_cnt_q;
        wait_inc    = 1'b0;
        wait_clr    = 1'b0;
        m_ack       = 1'b0;
        m_err       = 1'b0;
        p_rd        = 1'b0;
        p_wr        = 1'b0;
        p_addr      = j1_addr;
        p_dout      = j1_dout;

        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    cmd_we_d    = m_we;
                    cmd_addr_d  = m_addr;
                    cmd_wdata_d = m_wdata;
                    if (is_ram_addr(m_addr)) begin
                        err_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cpu_act) begin
                    wait_inc = 1'b1;
                end else begin
                    p_rd   = ~cmd_we_q;
                    p_wr   = cmd_we_q;
                    p_addr = cmd_addr_q;
                    p_dout = cmd_wdata_q;
                    if (!cmd_we_q) begin
                        rdata_d = p_din;
                    end
                    grant_cnt_d = grant_cnt_q + 16'd1;
                    state_d     = ACK;
                end
            end
            ACK: begin
                m_ack    = 1'b1;
                m_err    = err_q;
                err_d    = 1'b0;
                wait_clr = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // the CPU has no wait input, so its strobes always own the bus
        if (cpu_act) begin
            p_rd   = j1_rd;
            p_wr   = j1_wr;
            p_addr = j1_addr;
            p_dout = j1_dout;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    sat_counter #(
        .W      (WAIT_W),
        .THRESH (STARVE_LIMIT)
    ) u_wait_cnt (
        .clk_i     (sys_clk_i),
        .rst_n_i   (sys_rst_n_i),
        .inc_i     (wait_inc),
        .clr_i     (wait_clr),
        .reached_o (starve)
    );

    assign m_rdata   = rdata_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_j1_io_arbiter.sv
// tb/tb_j1_io_arbiter.sv - directed self-checking bench for j1_io_arbiter
module tb_j1_io_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        j1_rd, j1_wr;
    logic [15:0] j1_addr, j1_dout, j1_din;
    logic        m_req, m_we;
    logic [15:0] m_addr, m_wdata;
    logic        m_ack, m_err;
    logic [15:0] m_rdata;
    logic        p_rd, p_wr;
    logic [15:0] p_addr, p_dout, p_din;
    logic        starve;
    logic [15:0] grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    j1_io_arbiter #(
        .WAIT_W       (8),
        .STARVE_LIMIT (4)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .j1_rd       (j1_rd),
        .j1_wr       (j1_wr),
        .j1_addr     (j1_addr),
        .j1_dout     (j1_dout),
        .j1_din      (j1_din),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_rdata     (m_rdata),
        .p_rd        (p_rd),
        .p_wr        (p_wr),
        .p_addr      (p_addr),
        .p_dout      (p_dout),
        .p_din       (p_din),
        .starve      (starve),
        .grant_cnt   (grant_cnt)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; j1_rd = 1'b0; j1_wr = 1'b0; j1_addr = '0; j1_dout = '0;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; p_din = '0;

        repeat (2) cyc();
        rst_n = 1'b1;
        p_din = 16'h7777;
        #1;
        expect_eq("rst_ack", m_ack, 0);
        expect_eq("rst_grant", grant_cnt, 0);
        expect_eq("rst_starve", starve, 0);
        expect_eq("rst_prd", p_rd, 0);
        expect_eq("rst_pwr", p_wr, 0);
        expect_eq("rst_rdata", m_rdata, 0);
        expect_eq("din_pass", j1_din, 16'h7777);

        // secondary read, CPU idle
        cyc();
        m_req = 1'b1; m_we = 1'b0; m_addr = 16'h4000; p_din = 16'hBEEF;
        cyc(); #1;
        expect_eq("rd_c1_prd", p_rd, 1);
        expect_eq("rd_c1_pwr", p_wr, 0);
        expect_eq("rd_c1_addr", p_addr, 16'h4000);
        expect_eq("rd_c1_ack", m_ack, 0);
        cyc();
        expect_eq("rd_c2_ack", m_ack, 1);
        expect_eq("rd_c2_err", m_err, 0);
        expect_eq("rd_c2_rdata", m_rdata, 16'hBEEF);
        expect_eq("rd_c2_grant", grant_cnt, 1);
        m_req = 1'b0;
        cyc();
        expect_eq("rd_c3_ack", m_ack, 0);

        // secondary write deferred by three CPU writes
        m_req = 1'b1; m_we = 1'b1; m_addr = 16'h8004; m_wdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            cyc();
            j1_wr = 1'b1; j1_addr = 16'h8100; j1_dout = 16'hAAAA;
            #1;
            expect_eq($sformatf("wr_cpu%0d_pwr", i), p_wr, 1);
            expect_eq($sformatf("wr_cpu%0d_addr", i), p_addr, 16'h8100);
            expect_eq($sformatf("wr_cpu%0d_dout", i), p_dout, 16'hAAAA);
        end
        cyc();
        j1_wr = 1'b0;
        #1;
        expect_eq("wr_bus_pwr", p_wr, 1);
        expect_eq("wr_bus_prd", p_rd, 0);
        expect_eq("wr_bus_addr", p_addr, 16'h8004);
        expect_eq("wr_bus_dout", p_dout, 16'h1234);
        expect_eq("wr_bus_ack", m_ack, 0);
        cyc();
        expect_eq("wr_ack", m_ack, 1);
        expect_eq("wr_err", m_err, 0);
        expect_eq("wr_grant", grant_cnt, 2);
        m_req = 1'b0;
        cyc();

        // RAM-space address errors out without a bus cycle
        m_req = 1'b1; m_we = 1'b0; m_addr = 16'h0010;
        cyc();
        expect_eq("err_ack", m_ack, 1);
        expect_eq("err_flag", m_err, 1);
        expect_eq("err_prd", p_rd, 0);
        expect_eq("err_pwr", p_wr, 0);
        expect_eq("err_grant", grant_cnt, 2);
        expect_eq("err_rdata_kept", m_rdata, 16'hBEEF);
        m_req = 1'b0;
        cyc();
        expect_eq("err_after_ack", m_ack, 0);
        expect_eq("err_after_err", m_err, 0);

        // starvation: CPU reads for 10 cycles while the secondary waits
        m_req = 1'b1; m_we = 1'b0; m_addr = 16'hC000; p_din = 16'h5A5A;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            j1_rd = 1'b1; j1_addr = 16'hC100;
            #1;
            expect_eq($sformatf("stv_c%0d_addr", i), p_addr, 16'hC100);
            expect_eq($sformatf("stv_c%0d_starve", i), starve, (i - 1 >= 4) ? 1 : 0);
        end
        cyc();
        j1_rd = 1'b0;
        #1;
        expect_eq("stv_bus_prd", p_rd, 1);
        expect_eq("stv_bus_addr", p_addr, 16'hC000);
        expect_eq("stv_bus_ack", m_ack, 0);
        expect_eq("stv_bus_starve", starve, 1);
        cyc();
        expect_eq("stv_ack", m_ack, 1);
        expect_eq("stv_rdata", m_rdata, 16'h5A5A);
        expect_eq("stv_ack_starve", starve, 1);
        expect_eq("stv_grant", grant_cnt, 3);
        m_req = 1'b0;
        cyc();
        expect_eq("stv_clear", starve, 0);
        expect_eq("stv_after_ack", m_ack, 0);

        // reset in the middle of ISSUE
        m_req = 1'b1; m_we = 1'b1; m_addr = 16'h4000; m_wdata = 16'h0F0F;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            j1_wr = 1'b1; j1_addr = 16'h8000;
        end
        #1;
        expect_eq("mid_starve_pre", starve, 1);
        rst_n = 1'b0; j1_wr = 1'b0; m_req = 1'b0;
        cyc();
        expect_eq("mid_rst_ack", m_ack, 0);
        expect_eq("mid_rst_starve", starve, 0);
        expect_eq("mid_rst_grant", grant_cnt, 0);
        expect_eq("mid_rst_rdata", m_rdata, 0);
        expect_eq("mid_rst_pwr", p_wr, 0);
        rst_n = 1'b1;
        cyc();
        expect_eq("mid_idle_ack", m_ack, 0);
        m_req = 1'b1; m_we = 1'b0; m_addr = 16'h4002; p_din = 16'h1111;
        cyc();
        expect_eq("post_prd", p_rd, 1);
        expect_eq("post_addr", p_addr, 16'h4002);
        cyc();
        expect_eq("post_ack", m_ack, 1);
        expect_eq("post_rdata", m_rdata, 16'h1111);
        expect_eq("post_grant", grant_cnt, 1);
        m_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/j1_io_arbiter.md
Name: j1_io_arbiter

Overview:
Shares the J1 core's single-cycle IO bus between the CPU and a secondary bus master, such as a debug/UART bridge or a DMA engine.
- The CPU has absolute priority and is never stalled; the J1 has no wait input.
- Secondary accesses use a req/ack handshake and are slotted into cycles where the CPU issues no IO access.
- Sits between the j1 IO port and the peripheral address decoder in the SoC top.

Parameters:
- WAIT_W, 8: width of the secondary-wait counter (saturating).
- STARVE_LIMIT, 200: wait count at or above which the starve flag asserts; must be < 2**WAIT_W.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- sys_rst_n_i  in  1  reset, synchronous, active-low.
- j1_rd  in  1  CPU IO read strobe.
- j1_wr  in  1  CPU IO write strobe.
- j1_addr  in  16  CPU IO address.
- j1_dout  in  16  CPU write data.
- j1_din  out  16  read data to CPU.
- m_req  in  1  secondary request; level, held until m_ack.
- m_we  in  1  secondary write (1) / read (0); stable while m_req.
- m_addr  in  16  secondary address; stable while m_req.
- m_wdata  in  16  secondary write data; stable while m_req.
- m_ack  out  1  one-cycle completion pulse.
- m_err  out  1  valid with m_ack; 1 = address outside IO space, no bus cycle issued.
- m_rdata  out  16  registered read data; valid from the m_ack cycle until the next read completes.
- p_rd  out  1  peripheral read strobe.
- p_wr  out  1  peripheral write strobe.
- p_addr  out  16  peripheral address.
- p_dout  out  16  peripheral write data.
- p_din  in  16  peripheral read data; combinational, same cycle.
- starve  out  1  secondary has waited >= STARVE_LIMIT cycles in ISSUE.
- grant_cnt  out  16  count of completed secondary bus cycles; wraps.

Behaviour:
- j1_din = p_din at all times, combinational, zero latency, so the CPU's same-cycle read works.
- cpu_act = j1_rd | j1_wr. When cpu_act=1, p_rd/p_wr/p_addr/p_dout pass j1_rd/j1_wr/j1_addr/j1_dout combinationally, regardless of FSM state.
- Otherwise, in state ISSUE with an IO-space command:
  - p_rd = ~cmd_we, p_wr = cmd_we.
  - p_addr = cmd_addr, p_dout = cmd_wdata.
- In all remaining cases: p_rd = p_wr = 0, p_addr = j1_addr, p_dout = j1_dout.
- FSM states IDLE, ISSUE, ACK; reset state IDLE.
- IDLE:
  - On m_req=1, capture m_we/m_addr/m_wdata into cmd_* registers.
  - If m_addr[15:14]==2'b00 (RAM space), go to ACK with err flag set.
  - Otherwise go to ISSUE.
- ISSUE:
  - If cpu_act, stay and increment wait_cnt (saturates at 2**WAIT_W-1).
  - Else drive the bus cycle; on a read, register p_din into m_rdata; increment grant_cnt; go to ACK.
- ACK: m_ack=1 for exactly one cycle, m_err=err flag; clear wait_cnt and err flag; go to IDLE. A still-high m_req in the next IDLE cycle starts a new transaction.
- Minimum latency is m_req sampled in IDLE at cycle 0, bus cycle at cycle 1, m_ack at cycle 2. The error path gives m_ack at cycle 1.
- starve = (wait_cnt >= STARVE_LIMIT), registered; clears when wait_cnt clears.
- Simultaneous CPU access and secondary ISSUE: the CPU wins and the secondary retries on every following cycle. Nothing is ever dropped.
- m_req deasserted while in ISSUE is a protocol violation; the captured command still completes and acks.
- Reset values (sys_rst_n_i=0 at a clock edge):
  - State IDLE; m_ack=0, m_err=0, m_rdata=0, starve=0, grant_cnt=0, wait_cnt=0, cmd_* = 0.
  - p_* follow the CPU pass-through rule.
- Reset mid-transaction aborts it with no ack.

Decomposition:
- Shared package j1_soc_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, ACK=2'd2);
  - the IO-space predicate constant IO_SPACE_MASK = 2'b00 on addr[15:14].
- One natural sub-module: sat_counter (parameterised width, inc/clr, saturates), instantiated for wait_cnt.
- Everything else stays flat.

Test Plan:
- Reset held 2 cycles, then released -> m_ack=0, grant_cnt=0, starve=0, p_rd=p_wr=0 with the CPU idle.
- CPU idle, m_req with m_we=0, m_addr=16'h4000, p_din=16'hBEEF -> p_rd=1 with p_addr=16'h4000 on cycle 1; m_ack and m_rdata=16'hBEEF on cycle 2; grant_cnt=1.
- Secondary write to 16'h8004, data 16'h1234, while j1_wr is high for 3 consecutive cycles -> CPU address/data on p_* for those 3 cycles; then p_wr=1 with p_addr=16'h8004 and p_dout=16'h1234; m_ack one cycle later.
- m_addr=16'h0010 -> m_ack=1 with m_err=1 at cycle 1; no p_rd/p_wr pulse; grant_cnt unchanged.
- STARVE_LIMIT=4, j1_rd held high for 10 cycles during ISSUE -> starve rises after 4 wait cycles; it clears in the cycle after ACK, and the access completes.
- sys_rst_n_i=0 during ISSUE -> no m_ack, state IDLE, all counters 0; a fresh request afterwards completes normally.
